spi_frame_extractor: RTL and testbench
======================================

# spi_frame_extractor

Downstream framing stage for the SPI AXIS byte interface. Consumes the raw MISO byte stream and discards idle filler bytes. Each chip frame is a header byte followed by N payload bytes. The block re-emits each frame as an 8-bit AXI-Stream packet with `tlast` on the final byte and an error flag in `tuser`. It feeds the readout FIFO/DMA path and keeps frame and error counters for register readback.

## Interface
Parameters:
- `IDLE_BYTE`, 8'hBC: idle filler byte; dropped outside frames.
- `IDLE_BYTE_ALT`, 8'hFF: second idle filler byte (bus floating high); dropped outside frames.
- `TIMEOUT_CYCLES`, 1024: stall limit in cycles with no accepted byte while in PAYLOAD before the frame is force-terminated; range 2..65535.

Ports:
- `clk`  in  1  system clock, same domain as the SPI AXIS interface.
- `resn`  in  1  reset; asynchronous and active-low.
- `enable`  in  1  when low in HUNT, all input bytes are accepted and discarded.
- `s_axis_tdata`  in  8  raw byte from the SPI MISO stream.
- `s_axis_tvalid`  in  1  input byte valid.
- `s_axis_tready`  out  1  input ready.
- `m_axis_tdata`  out  8  frame byte.
- `m_axis_tvalid`  out  1  output valid.
- `m_axis_tready`  in  1  output ready.
- `m_axis_tlast`  out  1  last byte of frame.
- `m_axis_tuser`  out  1  frame error; valid with `tlast`.
- `frame_count`  out  16  frames completed normally; wraps at 16'hFFFF -> 0.
- `error_count`  out  16  malformed headers plus timeouts; saturates at 16'hFFFF.
- `in_frame`  out  1  high while state is PAYLOAD.

## Operation
- Header format: `[7:5]` chip id (passed through, not interpreted); `[4:0]` payload length N.
- State machine has two states, HUNT and PAYLOAD. Reset state is HUNT.
- HUNT, on each accepted byte:
  - `enable`=0: discard the byte.
  - Byte equals `IDLE_BYTE` or `IDLE_BYTE_ALT`: discard.
  - Byte has N=0: malformed header. Discard it, increment `error_count`, stay in HUNT.
  - Otherwise: emit the header byte with `tlast`=0, load `remaining`=N, go to PAYLOAD.
- PAYLOAD, on each accepted byte:
  - Every byte is emitted, including idle-valued bytes (no filtering inside a frame).
  - `remaining` decrements per byte.
  - When `remaining`=1, emit the byte with `tlast`=1 and `tuser`=0, increment `frame_count`, go to HUNT.
  - `enable` is ignored in PAYLOAD; a started frame always completes or times out.
- Timeout:
  - A 16-bit stall counter clears on entry to PAYLOAD and on each accepted byte; it increments otherwise.
  - When it reaches `TIMEOUT_CYCLES` and the output register is free, emit pad byte 8'h00 with `tlast`=1 and `tuser`=1, increment `error_count`, go to HUNT.
  - While the output register is occupied the timeout stays pending. `s_axis_tready` is 0 while a timeout is pending, so the pad wins over late input.
- Output is a single register stage.
  - `s_axis_tready` = output register empty OR `m_axis_tready`, except during a pending timeout.
  - Discarded bytes (idle, disabled, malformed) are accepted whenever `s_axis_tready`=1 and never load the output register.
- Simultaneous events:
  - Output handshake and new load in the same cycle: the register reloads and `tvalid` stays 1.
  - `frame_count` increment and `error_count` increment cannot occur in the same cycle.

## Timing
- Reset values: `s_axis_tready`=0 during reset, 1 from the first clock after release; `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `frame_count`=0, `error_count`=0, `in_frame`=0, state=HUNT.
- Latency: an input handshake at edge k gives `m_axis_tvalid`=1 with that byte after edge k.
- Throughput: 1 byte/cycle with `m_axis_tready` held high.
- `m_axis_tdata`, `tlast` and `tuser` are stable while `tvalid`=1 and `tready`=0.
- `in_frame` rises the cycle after the header is accepted. It falls the cycle after the last byte or the pad byte is loaded.
- Counters update on the edge that loads the completing byte, or on the edge that consumes the malformed header.
- Reset asserted mid-frame returns everything to reset values immediately. The partial frame is lost and no `tlast` is emitted.
- Timeout: pad is loaded at the edge where the stall counter reaches `TIMEOUT_CYCLES`, i.e. `TIMEOUT_CYCLES` cycles after the last accepted byte, if the output register is free.

## Test plan
- Input BC BC 23 11 22 33 BC with `tready`=1 -> output 23, 11, 22, 33; `tlast` only on 33; `frame_count`=1; BC bytes absent.
- Input header 02, then payload BC FF -> output 02, BC, FF with `tlast` on FF; no idle filtering inside the frame.
- Input E0 (N=0), then 41 AA -> E0 dropped, `error_count`=1; output 41, AA with `tlast` on AA.
- `TIMEOUT_CYCLES`=8; input header 05 then one byte 11, then input idle -> output 05, 11, then 00 with `tlast`=1, `tuser`=1 eight cycles after byte 11 accepted; `error_count`=1; state HUNT.
- Random `m_axis_tready` toggling over 200 frames of random N=1..31 -> byte-exact stream, no loss or duplication, data stable during stalls, `frame_count`=200.
- `enable`=0 with input 23 11 22 33 -> all bytes accepted and discarded, no output. Reset asserted mid-frame -> all outputs return to reset values asynchronously; next header starts a clean frame.

Source files
------------

// File: rtl/spi_frame_extractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_frame_extractor
//  Purpose  : Strips idle filler from the raw SPI MISO byte stream and
//             re-emits each chip frame (header + N payload bytes) as an
//             AXI-Stream packet with tlast/tuser, plus frame/error counters.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_frame_extractor #(
  parameter logic [7:0]  IDLE_BYTE      = 8'hBC,
  parameter logic [7:0]  IDLE_BYTE_ALT  = 8'hFF,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resn,
  input  logic        enable,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [15:0] frame_count,
  output logic [15:0] error_count,
  output logic        in_frame
);

  localparam logic [0:0]  ST_HUNT       = 1'b0;
  localparam logic [0:0]  ST_PAYLOAD    = 1'b1;
  // The stall counter parks one below the limit: the edge that would take it
  // to TIMEOUT_CYCLES is the edge that loads the pad byte.
  localparam logic [15:0] C_STALL_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [0:0]  state_q,     state_d;
  logic [4:0]  remaining_q, remaining_d;
  logic [15:0] stall_q,     stall_d;
  logic [7:0]  tdata_q,     tdata_d;
  logic        tvalid_q,    tvalid_d;
  logic        tlast_q,     tlast_d;
  logic        tuser_q,     tuser_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q,   err_cnt_d;
  logic        rdy_en_q;

  logic w_out_free;
  logic w_to_pending;
  logic w_accept;
  logic w_is_idle;

  assign w_out_free    = ~tvalid_q | m_axis_tready;
  assign w_to_pending  = (state_q == ST_PAYLOAD) && (stall_q == C_STALL_LIMIT);
  assign s_axis_tready = rdy_en_q & w_out_free & ~w_to_pending;
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_is_idle     = (s_axis_tdata == IDLE_BYTE) || (s_axis_tdata == IDLE_BYTE_ALT);

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frame_count   = frame_cnt_q;
  assign error_count   = err_cnt_q;
  assign in_frame      = (state_q == ST_PAYLOAD);

  // Next-state: framing FSM, output register load/drain, stall timer, counters
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    stall_d     = stall_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;

    // Downstream consumed the held byte; a load below may refill it.
    if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end

    case (state_q)
      ST_HUNT: begin
        stall_d = 16'd0;
        if (w_accept && enable && !w_is_idle) begin
          if (s_axis_tdata[4:0] == 5'd0) begin
            // Zero-length header is malformed: swallow it and count it.
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
          end else begin
            tdata_d     = s_axis_tdata;
            tvalid_d    = 1'b1;
            tlast_d     = 1'b0;
            tuser_d     = 1'b0;
            remaining_d = s_axis_tdata[4:0];
            state_d     = ST_PAYLOAD;
          end
        end
      end

      default: begin
        if (w_accept) begin
          // Inside a frame every byte passes, idle-valued or not.
          stall_d     = 16'd0;
          tdata_d     = s_axis_tdata;
          tvalid_d    = 1'b1;
          tlast_d     = (remaining_q == 5'd1);
          tuser_d     = 1'b0;
          remaining_d = remaining_q - 5'd1;
          if (remaining_q == 5'd1) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = ST_HUNT;
          end
        end else if (w_to_pending) begin
          // Pad only once the output register can take it; input is held off.
          if (w_out_free) begin
            tdata_d  = 8'h00;
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tuser_d  = 1'b1;
            stall_d  = 16'd0;
            state_d  = ST_HUNT;
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
          end
        end else begin
          stall_d = stall_q + 16'd1;
        end
      end
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q     <= ST_HUNT;
      remaining_q <= 5'd0;
      stall_q     <= 16'd0;
      tdata_q     <= 8'h00;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      stall_q     <= stall_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      rdy_en_q    <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_extractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_frame_extractor
//  Purpose  : Directed self-checking bench for spi_frame_extractor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_extractor;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        resn;
  logic        enable;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;
  logic [15:0] fcount;
  logic [15:0] ecount;
  logic        in_frame;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_acc_cyc = 0;
  bit          rand_mode = 1'b0;
  int          low_run = 0;
  logic        prev_stall = 1'b0;
  logic [10:0] prev_val = '0;

  logic [9:0]  out_q[$];
  int          out_cyc_q[$];
  logic [9:0]  exp_q[$];

  spi_frame_extractor #(
    .IDLE_BYTE      (8'hBC),
    .IDLE_BYTE_ALT  (8'hFF),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk           (clk),
    .resn          (resn),
    .enable        (enable),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .frame_count   (fcount),
    .error_count   (ecount),
    .in_frame      (in_frame)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor at negedge: inputs are stable, so what is seen here happens at the next edge
  always @(negedge clk) begin
    if (resn) begin
      if (prev_stall)
        check("hold_stable", {21'd0, m_tvalid, m_tlast, m_tuser, m_tdata}, {21'd0, prev_val});
      prev_stall <= m_tvalid && !m_tready;
      prev_val   <= {1'b1, m_tlast, m_tuser, m_tdata};
      if (m_tvalid && m_tready) begin
        out_q.push_back({m_tuser, m_tlast, m_tdata});
        out_cyc_q.push_back(cyc);
      end
      if (s_tvalid && s_tready) last_acc_cyc <= cyc + 1;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_queues();
    out_q.delete();
    out_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    s_tvalid  = 1'b0;
    m_tready  = 1'b1;
    enable    = 1'b1;
    rand_mode = 1'b0;
    resn      = 1'b0;
    idle(2);
    resn = 1'b1;
    check("rdy_before_clk", 32'(s_tready), 32'd0);
    idle(1);
    check("rdy_after_clk", 32'(s_tready), 32'd1);
    clear_queues();
  endtask

  task automatic send(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
      if (rand_mode) begin
        if (low_run >= 3) m_tready = 1'b1;
        else              m_tready = ($urandom_range(0, 3) != 0);
        low_run = m_tready ? 0 : low_run + 1;
      end
    end
    if (!ok) check("send_timeout", 32'd0, 32'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic last, input logic user);
    exp_q.push_back({user, last, d});
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_len"}, 32'(out_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
      check(tag, {22'd0, out_q[i]}, {22'd0, exp_q[i]});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hdr;
    logic [7:0] b;
    int         n;

    resn = 1'b0; enable = 1'b1; s_tvalid = 1'b0; s_tdata = 8'h00; m_tready = 1'b1;
    #1;
    check("rst_tready",  32'(s_tready), 32'd0);
    check("rst_tvalid",  32'(m_tvalid), 32'd0);
    check("rst_tdata",   32'(m_tdata),  32'd0);
    check("rst_tlast",   32'(m_tlast),  32'd0);
    check("rst_tuser",   32'(m_tuser),  32'd0);
    check("rst_fcount",  32'(fcount),   32'd0);
    check("rst_ecount",  32'(ecount),   32'd0);
    check("rst_inframe", 32'(in_frame), 32'd0);
    do_reset();

    // Idle bytes around a 3-byte frame are stripped
    send(8'hBC); send(8'hBC); send(8'h23); send(8'h11); send(8'h22); send(8'h33); send(8'hBC);
    idle(4);
    push_exp(8'h23, 0, 0); push_exp(8'h11, 0, 0); push_exp(8'h22, 0, 0); push_exp(8'h33, 1, 0);
    cmp_stream("t1_stream");
    check("t1_fcount",  32'(fcount),   32'd1);
    check("t1_ecount",  32'(ecount),   32'd0);
    check("t1_inframe", 32'(in_frame), 32'd0);

    // Idle-valued payload bytes are kept
    do_reset();
    send(8'h02);
    check("t2_inframe_hdr", 32'(in_frame), 32'd1);
    send(8'hBC); send(8'hFF);
    idle(4);
    push_exp(8'h02, 0, 0); push_exp(8'hBC, 0, 0); push_exp(8'hFF, 1, 0);
    cmp_stream("t2_stream");
    check("t2_fcount", 32'(fcount), 32'd1);

    // Malformed header
    do_reset();
    send(8'hE0);
    check("t3_ecount_now", 32'(ecount), 32'd1);
    send(8'h41); send(8'hAA);
    idle(4);
    push_exp(8'h41, 0, 0); push_exp(8'hAA, 1, 0);
    cmp_stream("t3_stream");
    check("t3_fcount", 32'(fcount), 32'd1);
    check("t3_ecount", 32'(ecount), 32'd1);

    // Timeout pad
    do_reset();
    send(8'h05); send(8'h11);
    idle(14);
    push_exp(8'h05, 0, 0); push_exp(8'h11, 0, 0); push_exp(8'h00, 1, 1);
    cmp_stream("t4_stream");
    if (out_cyc_q.size() >= 3)
      check("t4_pad_delay", 32'(out_cyc_q[2] - last_acc_cyc), 32'(T));
    check("t4_ecount",  32'(ecount),   32'd1);
    check("t4_fcount",  32'(fcount),   32'd0);
    check("t4_inframe", 32'(in_frame), 32'd0);

    // Disabled: everything swallowed
    do_reset();
    enable = 1'b0;
    send(8'h23); send(8'h11); send(8'h22); send(8'h33);
    idle(3);
    check("t5_outcount", 32'(out_q.size()), 32'd0);
    check("t5_inframe",  32'(in_frame),     32'd0);
    check("t5_ecount",   32'(ecount),       32'd0);
    enable = 1'b1;

    // Asynchronous reset mid-frame
    do_reset();
    send(8'h23); send(8'h11);
    #2;
    resn = 1'b0;
    #1;
    check("t6_tvalid",  32'(m_tvalid), 32'd0);
    check("t6_tdata",   32'(m_tdata),  32'd0);
    check("t6_tlast",   32'(m_tlast),  32'd0);
    check("t6_inframe", 32'(in_frame), 32'd0);
    check("t6_tready",  32'(s_tready), 32'd0);
    idle(1);
    resn = 1'b1;
    idle(1);
    clear_queues();
    send(8'h41); send(8'h55);
    idle(4);
    push_exp(8'h41, 0, 0); push_exp(8'h55, 1, 0);
    cmp_stream("t6_stream");
    check("t6_fcount", 32'(fcount), 32'd1);

    // Backpressure: 200 frames with toggling m_tready
    do_reset();
    rand_mode = 1'b1;
    low_run   = 0;
    for (int f = 0; f < 200; f++) begin
      n   = $urandom_range(1, 31);
      hdr = {3'($urandom_range(0, 7)), 5'(n)};
      while (hdr == 8'hBC || hdr == 8'hFF) hdr = {3'($urandom_range(0, 7)), 5'(n)};
      push_exp(hdr, 0, 0);
      send(hdr);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        push_exp(b, (j == n - 1), 0);
        send(b);
      end
    end
    rand_mode = 1'b0;
    m_tready  = 1'b1;
    idle(10);
    cmp_stream("t7_stream");
    check("t7_fcount", 32'(fcount), 32'd200);
    check("t7_ecount", 32'(ecount), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
